// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                           |
// | Description : Stall/flush controller for a 5-stage RISC-V pipeline.      |
// |               Handles load-use stalls, taken-branch flushes and whole-   |
// |               pipeline freezes while data memory is busy. A branch that  |
// |               resolves during a freeze is remembered and applied when    |
// |               the freeze ends.                                           |
// |               Optional macro HAZARD_STATS_EN adds saturating stall,      |
// |               flush and load-use event counters.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,   // register index width
  parameter int CNT_W    = 4,   // memory-wait counter width
  parameter int MAX_WAIT = 15   // wait cycles before mem_timeout (< 2**CNT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             pc_sel_target,
  output logic             ifid_write,
  output logic             if_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] wait_cnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count,
  output logic [15:0]      lu_count
`endif
);

  // Saturation value of the wait counter and the timeout threshold at
  // counter width.
  localparam logic [CNT_W-1:0] c_CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_MAX_WAIT = CNT_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_br_pend;
  logic             w_br_pend_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             r_mem_timeout;
  logic             w_mem_timeout_nxt;

  logic             w_rd_nonzero;
  logic             w_rs1_match;
  logic             w_rs2_match;
  logic             w_lu;
  logic             w_br;
  logic             w_lu_stall;

  // Hazard terms. A destination of x0 never creates a dependency, and the
  // rs2 comparison only matters when the ID instruction actually reads rs2.
  assign w_rd_nonzero = (ex_rd != '0);
  assign w_rs1_match  = (ex_rd == id_rs1);
  assign w_rs2_match  = id_uses_rs2 & (ex_rd == id_rs2);
  assign w_lu         = ex_mem_read & w_rd_nonzero & (w_rs1_match | w_rs2_match);

  // A branch either resolves now or was deferred across a memory freeze.
  assign w_br = branch_taken | r_br_pend;

  assign mem_timeout = r_mem_timeout;
  assign wait_cnt    = r_wait_cnt;

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_br_pend     <= 1'b0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_br_pend     <= w_br_pend_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
    end
  end

  // Next-state logic and control outputs, priority: reset, memory freeze,
  // branch flush, load-use stall, normal flow.
  always_comb begin
    w_state_nxt       = r_state;
    w_br_pend_nxt     = r_br_pend;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_timeout_nxt = r_mem_timeout;
    pc_write          = 1'b0;
    pc_sel_target     = 1'b0;
    ifid_write        = 1'b0;
    if_flush          = 1'b0;
    idex_bubble       = 1'b0;
    pipe_hold         = 1'b0;
    w_lu_stall        = 1'b0;

    if (reset) begin
      // Squash whatever sits in IF/ID and ID/EX while the core is held.
      if_flush          = 1'b1;
      idex_bubble       = 1'b1;
      w_state_nxt       = RUN;
      w_br_pend_nxt     = 1'b0;
      w_wait_cnt_nxt    = '0;
      w_mem_timeout_nxt = 1'b0;
    end else if (dmem_busy) begin
      // Freeze every stage; a branch seen now is parked in br_pend.
      pipe_hold   = 1'b1;
      w_state_nxt = MEM_WAIT;
      if (r_state == RUN) begin
        w_wait_cnt_nxt = CNT_W'(1);
        w_br_pend_nxt  = branch_taken;
      end else begin
        w_wait_cnt_nxt = (r_wait_cnt == c_CNT_SAT) ? r_wait_cnt
                                                   : r_wait_cnt + 1'b1;
        w_br_pend_nxt  = r_br_pend | branch_taken;
      end
      if (w_wait_cnt_nxt >= c_MAX_WAIT) begin
        w_mem_timeout_nxt = 1'b1;
      end
    end else begin
      // Memory available: leave any freeze and resolve the front end.
      w_state_nxt    = RUN;
      w_wait_cnt_nxt = '0;
      w_br_pend_nxt  = 1'b0;
      if (w_br) begin
        // The ID instruction is squashed, so a load-use match is moot.
        pc_write      = 1'b1;
        pc_sel_target = 1'b1;
        if_flush      = 1'b1;
        idex_bubble   = 1'b1;
      end else if (w_lu) begin
        // One-cycle stall: the bubble removes the load from the compare.
        idex_bubble = 1'b1;
        w_lu_stall  = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  logic [15:0] r_lu_count;

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign lu_count     = r_lu_count;

  // Saturating event counters; reset cycles are never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_lu_count     <= '0;
    end else begin
      if (!pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (if_flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
      if (w_lu_stall && (r_lu_count != 16'hFFFF)) begin
        r_lu_count <= r_lu_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                        |
// | Description : Scoreboard bench for pipe_hazard_ctrl. The driver issues   |
// |               directed and random stimulus and queues the expected       |
// |               response from a behavioural model; a monitor pops and      |
// |               compares on the falling edge.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  localparam int REG_W    = 5;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs2, ex_mem_read, branch_taken, dmem_busy;
  logic             pc_write, pc_sel_target, ifid_write, if_flush;
  logic             idex_bubble, pipe_hold, mem_timeout;
  logic [CNT_W-1:0] wait_cnt;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cycles;
  logic [15:0]      flush_count, lu_count;
`endif

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .pc_sel_target(pc_sel_target),
    .ifid_write(ifid_write), .if_flush(if_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .mem_timeout(mem_timeout), .wait_cnt(wait_cnt)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .lu_count(lu_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected response for one cycle. Output vector order:
  // pc_write pc_sel_target ifid_write if_flush idex_bubble pipe_hold mem_timeout wait_cnt
  typedef struct {
    int          cyc;
    logic [10:0] outs;
    int          stall;
    int          flush;
    int          lu;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;
  int   cyc      = 0;

  // Behavioural model: "frozen" tells whether the previous cycle was a
  // memory freeze; pend holds a branch deferred by that freeze.
  bit   m_frozen = 1'b0;
  bit   m_pend   = 1'b0;
  int   m_cnt    = 0;
  bit   m_tmo    = 1'b0;
  int   m_stall  = 0;
  int   m_flush  = 0;
  int   m_lu     = 0;

  task automatic drive(input bit rst, input bit busy, input bit bt, input bit mr,
                       input int rd, input int rs1, input int rs2, input bit u2);
    bit   pw, ps, iw, fl, bb, ph, hazard;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; dmem_busy = busy; branch_taken = bt; ex_mem_read = mr;
    ex_rd = REG_W'(rd); id_rs1 = REG_W'(rs1); id_rs2 = REG_W'(rs2); id_uses_rs2 = u2;
    cyc++;

    hazard = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
    {pw, ps, iw, fl, bb, ph} = 6'b0;
    if (rst)                 begin fl = 1; bb = 1; end
    else if (busy)           begin ph = 1; end
    else if (bt || m_pend)   begin pw = 1; ps = 1; fl = 1; bb = 1; end
    else if (hazard)         begin bb = 1; end
    else                     begin pw = 1; iw = 1; end

    e.cyc   = cyc;
    e.outs  = {pw, ps, iw, fl, bb, ph, m_tmo, CNT_W'(m_cnt)};
    e.stall = m_stall; e.flush = m_flush; e.lu = m_lu;
    sb.push_back(e);

    // Advance the model to the next cycle.
    if (rst) begin
      m_frozen = 0; m_pend = 0; m_cnt = 0; m_tmo = 0;
      m_stall = 0; m_flush = 0; m_lu = 0;
    end else begin
      if (!pw) m_stall++;
      if (fl)  m_flush++;
      if (!busy && !(bt || m_pend) && hazard) m_lu++;
      if (busy) begin
        m_cnt  = m_frozen ? ((m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT) : 1;
        m_pend = m_frozen ? (m_pend | bt) : bt;
        if (m_cnt >= MAX_WAIT) m_tmo = 1;
        m_frozen = 1;
      end else begin
        m_frozen = 0; m_pend = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [10:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_write, pc_sel_target, ifid_write, if_flush, idex_bubble,
             pipe_hold, mem_timeout, wait_cnt};
      checks++;
      if (act !== e.outs) begin
        failures++;
        $display("FAIL outputs cyc=%0d actual=%b required=%b (pw ps iw fl bb ph tmo cnt)",
                 e.cyc, act, e.outs);
      end
      checks++;
      if ((if_flush & ifid_write) !== 1'b0) begin
        failures++;
        $display("FAIL flush_write_excl cyc=%0d actual=%b required=0", e.cyc,
                 if_flush & ifid_write);
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (stall_cycles !== 32'(e.stall) || flush_count !== 16'(e.flush) ||
          lu_count !== 16'(e.lu)) begin
        failures++;
        $display("FAIL stats cyc=%0d actual=%0d/%0d/%0d required=%0d/%0d/%0d", e.cyc,
                 stall_cycles, flush_count, lu_count, e.stall, e.flush, e.lu);
      end
`endif
    end else if (done) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Stimulus: test-plan scenarios first, then randomized traffic.
  initial begin
    int busy_left;
    bit busy;
    reset = 1; dmem_busy = 0; branch_taken = 0; ex_mem_read = 0;
    ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Load-use on rs1, then x0 destination which must not stall.
    drive(0, 0, 0, 1, 5, 5, 0, 0);
    idle(2);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // rs2 match only counts when rs2 is read.
    drive(0, 0, 0, 1, 7, 1, 7, 0);
    drive(0, 0, 0, 1, 7, 1, 7, 1);
    idle(1);
    // Branch together with a load-use hazard.
    drive(0, 0, 1, 1, 5, 5, 0, 0);
    idle(1);
    // Four busy cycles with a branch in the second; deferred to release.
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Long freeze: timeout and saturation, sticky until reset.
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Reset in the middle of a freeze with a pending branch.
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    busy_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy_left == 0 && $urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 20);
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      drive(($urandom_range(0, 99) == 0), busy, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom));
    end
    @(posedge clk);
    done = 1'b1;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives the IF/ID buffer's flush and write-enable, the PC write-enable and PC-source select, the ID/EX bubble, and the EX/MEM and MEM/WB write-enables.
- Detects load-use hazards, applies taken-branch flushes, and freezes the whole pipeline while the data memory is busy.
- Remembers a branch that resolves during a freeze and applies it when the freeze ends.

Parameters:
REG_W, 5, register index width
CNT_W, 4, width of the memory-wait counter
MAX_WAIT, 15, wait cycles before mem_timeout asserts (must be less than 2^CNT_W)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
id_rs1  in  REG_W  rs1 field of the instruction in ID
id_rs2  in  REG_W  rs2 field of the instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types)
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_W  destination register of the EX instruction
branch_taken  in  1  EX resolved a taken branch or jump this cycle
dmem_busy  in  1  data memory cannot complete this cycle
pc_write  out  1  PC register load enable
pc_sel_target  out  1  1 selects the branch target, 0 selects PC+4
ifid_write  out  1  IF/ID buffer write enable
if_flush  out  1  IF/ID buffer flush
idex_bubble  out  1  zero the ID/EX control signals
pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB
mem_timeout  out  1  sticky error flag
wait_cnt  out  CNT_W  current memory-wait count

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- State and outputs:
  - Two states, RUN and MEM_WAIT, plus registers br_pend, wait_cnt and mem_timeout.
  - All outputs are combinational from state, registers and inputs.
  - Load-use hazard lu = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
  - Effective branch br = branch_taken | br_pend.
- While reset = 1:
  - pc_write = 0, ifid_write = 0, if_flush = 1, idex_bubble = 1, pipe_hold = 0, pc_sel_target = 0.
  - On the clock edge: state goes to RUN; br_pend, wait_cnt and mem_timeout go to 0.
- RUN, evaluated in priority order:
  1. dmem_busy = 1:
     - Freeze everything: pc_write = 0, ifid_write = 0, pipe_hold = 1, if_flush = 0, idex_bubble = 0.
     - Next state MEM_WAIT, wait_cnt goes to 1.
     - br_pend is set to branch_taken.
  2. br = 1:
     - pc_write = 1, pc_sel_target = 1, if_flush = 1, idex_bubble = 1, ifid_write = 0.
     - br_pend is cleared.
     - A load-use hazard in the same cycle is ignored, because the ID instruction is being squashed.
  3. lu = 1:
     - pc_write = 0, ifid_write = 0, idex_bubble = 1, if_flush = 0.
     - State stays RUN. The bubble clears the hazard on the next cycle, so the stall lasts exactly 1 cycle.
  4. Otherwise: pc_write = 1, ifid_write = 1, all other outputs 0.
- MEM_WAIT:
  - While dmem_busy = 1:
    - Freeze exactly as in RUN case 1.
    - wait_cnt increments and saturates at 2^CNT_W - 1.
    - br_pend |= branch_taken.
    - When wait_cnt reaches MAX_WAIT, mem_timeout sets and stays set until reset.
    - The state remains MEM_WAIT.
  - When dmem_busy = 0:
    - Outputs follow RUN cases 2–4, using br.
    - Next state RUN, wait_cnt goes to 0, br_pend clears.
- Boundaries:
  - ex_rd = 0 never stalls.
  - dmem_busy takes priority over a simultaneous branch; the branch is deferred via br_pend, not lost.
  - if_flush and ifid_write are never both 1.
  - Reset during MEM_WAIT returns to RUN on the next edge, discarding br_pend.

Optional Feature:
Macro HAZARD_STATS_EN.
- When defined, adds three outputs, all cleared by reset and saturating (no wrap):
  - stall_cycles (32 bits): increments on every cycle with pc_write = 0 and reset = 0.
  - flush_count (16 bits): increments on each if_flush cycle outside reset.
  - lu_count (16 bits): increments on each load-use stall cycle.
- When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
- reset = 1 for 2 cycles, then 0 with no hazards -> during reset if_flush = 1 and pc_write = 0; afterwards pc_write = 1, ifid_write = 1 and all other outputs 0.
- ex_mem_read = 1, ex_rd = 5, id_rs1 = 5 for 1 cycle, then ex_mem_read = 0 -> exactly 1 cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; then normal flow. Repeat with ex_rd = 0 -> no stall.
- ex_mem_read = 1, ex_rd = 7, id_rs2 = 7, with id_uses_rs2 = 0, then 1 -> stall occurs only when id_uses_rs2 = 1.
- branch_taken = 1 while lu = 1 -> if_flush = 1, pc_sel_target = 1, pc_write = 1, ifid_write = 0 in that cycle; no load-use stall.
- dmem_busy = 1 for 4 cycles with branch_taken pulsed in the 2nd busy cycle -> pipe_hold = 1 and pc_write = 0 for 4 cycles, wait_cnt counts 1, 2, 3, 4; in the cycle dmem_busy drops, if_flush = 1 and pc_sel_target = 1; wait_cnt returns to 0.
- dmem_busy held for 20 cycles with MAX_WAIT = 15 -> mem_timeout rises when wait_cnt = 15 and stays high after dmem_busy drops until reset = 1.
